// File: rtl/seq_comparator.sv
// ---------------------------------------------------------------------------
// seq_comparator
//
// Sequential magnitude comparator. Two WIDTH-bit operands are compared one
// CHUNK-bit slice per clock, starting with the most significant slice. The
// comparison stops at the first slice that differs, so the latency depends
// on where the operands first diverge (1..NCHUNK cycles).
//
// In signed mode only the top slice carries the sign bit, so only that slice
// is compared as two's complement. Once the top slices match, the signs are
// equal and every lower slice orders the same way as plain unsigned values.
//
// Ports
//   clk          single clock, all state updates on its rising edge
//   n_rst        synchronous active-low reset
//   start        request a comparison (only looked at while idle)
//   signed_mode  1 = two's-complement compare, 0 = unsigned (sampled w/ start)
//   a, b         operands (sampled with start)
//   busy         high while a comparison is in progress
//   done         one-cycle pulse when gt/lt/eq receive a new result
//   gt, lt, eq   last completed result (one-hot), held until the next one
// ---------------------------------------------------------------------------
module seq_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // WIDTH must be a whole multiple of CHUNK; NCHUNK is the slice count.
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

  typedef enum logic {
    IDLE,
    CMP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic             top_signed;
  logic             slice_gt;
  logic             slice_lt;

  // Select the slice currently under comparison and order it. Only the top
  // slice in signed mode treats its MSB as a sign bit.
  always_comb begin
    slice_a    = a_q[int'(idx) * CHUNK +: CHUNK];
    slice_b    = b_q[int'(idx) * CHUNK +: CHUNK];
    top_signed = signed_q && (idx == TOP_IDX);
    if (top_signed) begin
      slice_gt = $signed(slice_a) > $signed(slice_b);
      slice_lt = $signed(slice_a) < $signed(slice_b);
    end else begin
      slice_gt = slice_a > slice_b;
      slice_lt = slice_a < slice_b;
    end
  end

  // Control FSM with registered outputs. done defaults low every cycle so it
  // only pulses in the first IDLE cycle after a comparison finishes; because
  // that cycle is already IDLE, a start arriving there is accepted at once.
  // gt/lt/eq are only written on completion, so a new start leaves the
  // previous result visible until the next one lands.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            idx      <= TOP_IDX;
            busy     <= 1'b1;
            state    <= CMP;
          end
        end
        CMP: begin
          if (slice_gt || slice_lt) begin
            // First differing slice decides the whole comparison.
            gt    <= slice_gt;
            lt    <= slice_lt;
            eq    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == '0) begin
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
